fetch_sequencer: RTL and testbench

- Program-counter sequencer and fetch controller for the 256-word instruction ROM.
- Drives the ROM word address and its hold input.
- Tracks the one-cycle synchronous read latency, so the fetched word and its PC reach decode with a valid flag.
- Handles pipeline-hazard stalls, branch/jump redirects with flush of the wrong-path word, and an optional halt on an all-zero word.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/sat_counter.sv | 35 +++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Contents:
//   fetch_state_t   - fetch FSM states (StRun, StStall, StHalt)
//   NOP_INSTR       - instruction presented to decode when no valid fetch is held
//   DEF_ADDR_W      - default ROM word-address width
//   DEF_IMEM_DEPTH  - default ROM depth in words
package fetch_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StHalt  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_IMEM_DEPTH = 256;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the count
//   en_i   - increment request for this edge
//   cnt_o  - current count; sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and fetch controller for a synchronous-read instruction ROM.
// Drives the ROM address/hold, tracks the one-cycle read latency and hands decode the
// fetched word with its PC and a valid flag. Handles hazard stalls and redirects (the word
// captured on the redirect edge is flushed).
// Build option: FETCH_HALT_ON_ZERO_EN - when defined, consuming an all-zero word halts
// fetch until reset or redirect; when undefined, zero is an ordinary word and halted=0.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   hazard                        - stall request from the hazard unit
//   redirect_valid, redirect_addr - taken branch/jump and its target word address
//   imem_addr, imem_hold          - ROM word address and hold
//   imem_rdata                    - registered ROM read data
//   if_valid, if_pc, if_instr     - fetched word to decode (NOP when not valid)
//   stalled, halted               - FSM status
//   fetch_count                   - saturating count of consumed fetches
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_hold,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              stalled,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redir_pc;
  logic              zero_word;
  logic              consume;

  assign pc_inc   = (pc_q == ADDR_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
  assign redir_pc = ADDR_W'(32'(redirect_addr) % IMEM_DEPTH);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_word = (imem_rdata == 32'h0);
`else
  assign zero_word = 1'b0;
`endif

  // Decode consumes the held word when nothing stalls or flushes it. HALT always has
  // if_valid_q=0, so no state qualifier is needed.
  assign consume = if_valid_q & ~hazard & ~redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (redirect_valid) begin
      // Word captured on this edge is from the wrong path.
      pc_d       = redir_pc;
      if_valid_d = 1'b0;
      state_d    = StRun;
    end else if (hazard && (state_q != StHalt)) begin
      state_d = StStall;
    end else if (state_q == StHalt) begin
      if_valid_d = 1'b0;
    end else if (if_valid_q && zero_word) begin
      state_d    = StHalt;
      if_valid_d = 1'b0;
    end else begin
      state_d    = StRun;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= ADDR_W'(RESET_PC);
      if_pc_q    <= ADDR_W'(RESET_PC);
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fetch_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (consume),
    .cnt_o(fetch_count)
  );

  assign imem_addr = pc_q;
  assign imem_hold = (hazard & ~redirect_valid) | (state_q == StHalt);
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_valid_q ? imem_rdata : NOP_INSTR;
  assign stalled   = (state_q == StStall);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. DUT a: RESET_PC=0, 16-bit counter, full stimulus.
// DUT b: RESET_PC=255, 3-bit counter, free-running (wrap and saturation).
module tb_fetch_sequencer;
  import fetch_pkg::*;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        a_hazard, a_redir;
  logic [7:0]  a_redir_addr;
  logic [7:0]  a_addr, a_pc;
  logic        a_hold, a_valid, a_stalled, a_halted;
  logic [31:0] a_rdata, a_instr;
  logic [15:0] a_count;
  logic        b_hazard, b_redir;
  logic [7:0]  b_redir_addr;
  logic [7:0]  b_addr, b_pc;
  logic        b_hold, b_valid, b_stalled, b_halted;
  logic [31:0] b_rdata, b_instr;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return (a == 8'd19) ? 32'h0 : (32'hC0DE_0000 | {24'h0, a});
  endfunction

  always_ff @(posedge clk) if (!a_hold) a_rdata <= rom_word(a_addr);
  always_ff @(posedge clk) if (!b_hold) b_rdata <= rom_word(b_addr);

  fetch_sequencer #(.ADDR_W(8), .IMEM_DEPTH(256), .RESET_PC(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .hazard(a_hazard), .redirect_valid(a_redir),
    .redirect_addr(a_redir_addr), .imem_addr(a_addr), .imem_hold(a_hold),
    .imem_rdata(a_rdata), .if_valid(a_valid), .if_pc(a_pc), .if_instr(a_instr),
    .stalled(a_stalled), .halted(a_halted), .fetch_count(a_count)
  );

  fetch_sequencer #(.ADDR_W(8), .IMEM_DEPTH(256), .RESET_PC(255), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .hazard(b_hazard), .redirect_valid(b_redir),
    .redirect_addr(b_redir_addr), .imem_addr(b_addr), .imem_hold(b_hold),
    .imem_rdata(b_rdata), .if_valid(b_valid), .if_pc(b_pc), .if_instr(b_instr),
    .stalled(b_stalled), .halted(b_halted), .fetch_count(b_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One edge, then sample 1 ns later. DUT b is checked over its first 12 fetch cycles.
  task automatic tick();
    logic [7:0] e_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc <= 12) begin
      e_pc = 8'(255 + cyc - 1);
      check_eq("b_valid", 32'(b_valid), 32'd1);
      check_eq("b_pc", 32'(b_pc), 32'(e_pc));
      check_eq("b_addr", 32'(b_addr), 32'(8'(255 + cyc)));
      check_eq("b_instr", b_instr, rom_word(e_pc));
      check_eq("b_count", 32'(b_count), (cyc > 8) ? 32'd7 : 32'(cyc - 1));
    end
  endtask

  initial begin
    int c;
    c = HaltEn ? 7 : 8;
    rst = 1'b1;
    a_hazard = 1'b0; a_redir = 1'b0; a_redir_addr = 8'd0;
    b_hazard = 1'b0; b_redir = 1'b0; b_redir_addr = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_eq("rst_a_addr", 32'(a_addr), 32'd0);
    check_eq("rst_a_pc", 32'(a_pc), 32'd0);
    check_eq("rst_a_valid", 32'(a_valid), 32'd0);
    check_eq("rst_a_instr", a_instr, NOP_INSTR);
    check_eq("rst_a_stalled", 32'(a_stalled), 32'd0);
    check_eq("rst_a_halted", 32'(a_halted), 32'd0);
    check_eq("rst_a_count", 32'(a_count), 32'd0);
    check_eq("rst_b_addr", 32'(b_addr), 32'd255);
    check_eq("rst_b_count", 32'(b_count), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_a_valid", 32'(a_valid), 32'd0);

    // Sequential fetch
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("seq_addr", 32'(a_addr), 32'(k));
      check_eq("seq_pc", 32'(a_pc), 32'(k - 1));
      check_eq("seq_valid", 32'(a_valid), 32'd1);
      check_eq("seq_instr", a_instr, rom_word(8'(k - 1)));
      check_eq("seq_count", 32'(a_count), 32'(k - 1));
    end

    // Hazard stall for 3 edges with if_pc=2
    a_hazard = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_stalled", 32'(a_stalled), 32'd1);
      check_eq("stall_hold", 32'(a_hold), 32'd1);
      check_eq("stall_addr", 32'(a_addr), 32'd3);
      check_eq("stall_pc", 32'(a_pc), 32'd2);
      check_eq("stall_instr", a_instr, rom_word(8'd2));
      check_eq("stall_count", 32'(a_count), 32'd2);
    end
    a_hazard = 1'b0;
    tick();
    check_eq("resume_pc", 32'(a_pc), 32'd3);
    check_eq("resume_instr", a_instr, rom_word(8'd3));
    check_eq("resume_stalled", 32'(a_stalled), 32'd0);
    check_eq("resume_count", 32'(a_count), 32'd3);
    tick();
    check_eq("pre_redir_addr", 32'(a_addr), 32'd5);
    check_eq("pre_redir_count", 32'(a_count), 32'd4);

    // Redirect to 17 at pc_q=5
    a_redir = 1'b1; a_redir_addr = 8'd17;
    tick();
    check_eq("redir_valid", 32'(a_valid), 32'd0);
    check_eq("redir_addr", 32'(a_addr), 32'd17);
    check_eq("redir_instr", a_instr, NOP_INSTR);
    check_eq("redir_count", 32'(a_count), 32'd4);
    a_redir = 1'b0;
    tick();
    check_eq("tgt_pc", 32'(a_pc), 32'd17);
    check_eq("tgt_valid", 32'(a_valid), 32'd1);
    check_eq("tgt_instr", a_instr, rom_word(8'd17));
    tick();
    tick();
    check_eq("zero_pc", 32'(a_pc), 32'd19);
    check_eq("zero_instr", a_instr, 32'h0);
    check_eq("zero_count", 32'(a_count), 32'd6);

    // All-zero word: halts only with the option built in
    tick();
    check_eq("halt_halted", 32'(a_halted), 32'(HaltEn));
    check_eq("halt_valid", 32'(a_valid), 32'(!HaltEn));
    check_eq("halt_hold", 32'(a_hold), 32'(HaltEn));
    check_eq("halt_count", 32'(a_count), 32'd7);
    check_eq("halt_addr", 32'(a_addr), HaltEn ? 32'd20 : 32'd21);
    tick();
    check_eq("halt2_halted", 32'(a_halted), 32'(HaltEn));
    check_eq("halt2_count", 32'(a_count), 32'(c));
    check_eq("halt2_addr", 32'(a_addr), HaltEn ? 32'd20 : 32'd22);

    // Redirect to 0 restarts fetch
    a_redir = 1'b1; a_redir_addr = 8'd0;
    tick();
    check_eq("restart_halted", 32'(a_halted), 32'd0);
    check_eq("restart_valid", 32'(a_valid), 32'd0);
    check_eq("restart_addr", 32'(a_addr), 32'd0);
    check_eq("restart_count", 32'(a_count), 32'(c));
    a_redir = 1'b0;
    tick();
    check_eq("restart_pc", 32'(a_pc), 32'd0);
    check_eq("restart_instr", a_instr, rom_word(8'd0));
    tick();
    tick();
    check_eq("run_pc", 32'(a_pc), 32'd2);
    check_eq("run_count", 32'(a_count), 32'(c + 2));

    // Redirect and hazard together at pc_q=3, target 9
    a_hazard = 1'b1; a_redir = 1'b1; a_redir_addr = 8'd9;
    #1;
    check_eq("rh_hold", 32'(a_hold), 32'd0);
    tick();
    check_eq("rh_stalled", 32'(a_stalled), 32'd0);
    check_eq("rh_valid", 32'(a_valid), 32'd0);
    check_eq("rh_addr", 32'(a_addr), 32'd9);
    check_eq("rh_count", 32'(a_count), 32'(c + 2));
    a_hazard = 1'b0; a_redir = 1'b0;
    tick();
    check_eq("rh_tgt_pc", 32'(a_pc), 32'd9);
    check_eq("rh_tgt_instr", a_instr, rom_word(8'd9));
    tick();
    check_eq("rh_next_count", 32'(a_count), 32'(c + 3));

    // Redirect to the current pc_q still costs a bubble
    a_redir = 1'b1; a_redir_addr = 8'd11;
    tick();
    check_eq("self_valid", 32'(a_valid), 32'd0);
    check_eq("self_addr", 32'(a_addr), 32'd11);
    a_redir = 1'b0;
    tick();
    check_eq("self_pc", 32'(a_pc), 32'd11);
    check_eq("self_instr", a_instr, rom_word(8'd11));

    // Asynchronous reset in the middle of a stall
    a_hazard = 1'b1;
    tick();
    check_eq("pre_rst_stalled", 32'(a_stalled), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_stalled", 32'(a_stalled), 32'd0);
    check_eq("arst_addr", 32'(a_addr), 32'd0);
    check_eq("arst_valid", 32'(a_valid), 32'd0);
    check_eq("arst_count", 32'(a_count), 32'd0);
    a_hazard = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst_valid", 32'(a_valid), 32'd1);
    check_eq("post_rst_pc", 32'(a_pc), 32'd0);
    check_eq("post_rst_addr", 32'(a_addr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
